// File: rtl/lru_press_driver.sv
// Request FIFO feeding a button-press sequencer: each queued slot becomes one
// press held for HOLD_TICKS timer ticks, followed by GAP_TICKS ticks with all buttons low.
module lru_press_driver #(
  parameter int HOLD_TICKS = 3,
  parameter int GAP_TICKS  = 1,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       timedClk,
  input  logic                       req_valid,
  input  logic [1:0]                 req_slot,
  output logic                       req_ready,
  output logic                       b1,
  output logic                       b2,
  output logic                       b3,
  output logic                       b4,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int HOLD_EFF = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
  localparam int CNT_MAX  = (HOLD_EFF > GAP_TICKS) ? HOLD_EFF : GAP_TICKS;
  localparam int CW       = $clog2(CNT_MAX) + 1;
  localparam int AW       = $clog2(DEPTH);
  localparam int LW       = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_EFF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      slot_q, slot_d;
  logic            done_q, done_d;
  logic [3:0]      btn_q, btn_d;
  logic            tc_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [1:0]      mem [DEPTH];

  logic tick;
  logic push;
  logic pop;

  assign tick      = timedClk & ~tc_q;
  assign req_ready = (level_q != LEVEL_FULL);
  assign push      = req_valid & req_ready;
  assign pop       = (state_q == IDLE) && (level_q != '0);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= req_slot;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          slot_d  = mem[rd_ptr_q];
          cnt_d   = '0;
          state_d = PRESS;
        end
      end
      PRESS: begin
        if (tick) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            if (GAP_TICKS == 0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Decode from next state so the button register tracks the state register exactly.
    btn_d = (state_d == PRESS) ? (4'b0001 << slot_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      slot_q   <= '0;
      done_q   <= 1'b0;
      btn_q    <= '0;
      tc_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      done_q  <= done_d;
      btn_q   <= btn_d;
      tc_q    <= timedClk;
      level_q <= level_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign b1    = btn_q[0];
  assign b2    = btn_q[1];
  assign b3    = btn_q[2];
  assign b4    = btn_q[3];
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign level = level_q;

endmodule

// File: tb/tb_lru_press_driver.sv
// Randomized bench for lru_press_driver: a queue-based reference model predicts
// every cycle, and a scoreboard matches each observed press and completion to accepted requests.
module tb_lru_press_driver;

  localparam int HOLD_TICKS = 3;
  localparam int GAP_TICKS  = 1;
  localparam int DEPTH      = 4;
  localparam int HOLD_EFF   = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
  localparam int LW         = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          timedClk = 1'b0;
  logic          req_valid = 1'b0;
  logic [1:0]    req_slot = 2'd0;
  logic          req_ready;
  logic          b1, b2, b3, b4;
  logic          busy;
  logic          done;
  logic [LW-1:0] level;

  int total = 0;
  int bad   = 0;

  lru_press_driver #(
    .HOLD_TICKS(HOLD_TICKS),
    .GAP_TICKS (GAP_TICKS),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .timedClk (timedClk),
    .req_valid(req_valid),
    .req_slot (req_slot),
    .req_ready(req_ready),
    .b1       (b1),
    .b2       (b2),
    .b3       (b3),
    .b4       (b4),
    .busy     (busy),
    .done     (done),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) begin
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Timer tick level: random high/low spans of 1..3 clocks, changed just after the clock edge.
  initial begin
    forever begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #2 timedClk = ~timedClk;
    end
  end

  // Reference model: mq is the request FIFO, m_active 0/1/2 = idle/pressing/gap,
  // m_left counts down the ticks still owed to the current phase.
  int         mq[$];
  int         sbq[$];
  int         m_active;
  int         m_left;
  int         m_slot;
  bit         m_done;
  bit         cap_v;
  logic [1:0] cap_slot;
  bit         pend_tick;
  logic       tc_last = 1'b1;
  logic [3:0] prev_b;
  logic       prev_busy;
  int         meas_hold;
  int         meas_gap;

  always @(negedge clk) begin : monitor
    logic [3:0] bv;
    logic [3:0] exp_b;
    bit         tk;
    bit         pushed;
    int         s;
    bv = {b4, b3, b2, b1};
    if (!rst) begin
      mq.delete();
      sbq.delete();
      m_active  = 0;
      m_left    = 0;
      m_slot    = 0;
      m_done    = 1'b0;
      cap_v     = 1'b0;
      pend_tick = 1'b0;
      tc_last   = 1'b1;
      prev_b    = 4'b0;
      prev_busy = 1'b0;
      meas_hold = 0;
      meas_gap  = 0;
    end else begin
      tk     = pend_tick;
      pushed = cap_v && (mq.size() != DEPTH);
      m_done = 1'b0;
      if (m_active == 0) begin
        if (mq.size() != 0) begin
          m_slot   = mq.pop_front();
          m_active = 1;
          m_left   = HOLD_EFF;
        end
      end else if (tk) begin
        m_left--;
        if (m_left == 0) begin
          if (m_active == 1 && GAP_TICKS > 0) begin
            m_active = 2;
            m_left   = GAP_TICKS;
          end else begin
            m_active = 0;
            m_done   = 1'b1;
          end
        end
      end
      if (pushed) begin
        mq.push_back(int'(cap_slot));
        sbq.push_back(int'(cap_slot));
      end
      if (prev_b != 4'b0 && tk) meas_hold++;
      if (prev_busy && prev_b == 4'b0 && tk) meas_gap++;

      exp_b = (m_active == 1) ? (4'b0001 << m_slot) : 4'b0000;
      check("buttons", 32'(bv), 32'(exp_b));
      check("busy", 32'(busy), 32'(m_active != 0));
      check("done", 32'(done), 32'(m_done));
      check("level", 32'(level), 32'(mq.size()));
      check("req_ready", 32'(req_ready), 32'(mq.size() != DEPTH));
      check("one_hot", 32'($countones(bv) <= 1), 32'd1);

      if (prev_b == 4'b0 && bv != 4'b0) begin
        if (sbq.size() == 0) begin
          check("press_without_request", 32'(bv), 32'd0);
        end else begin
          s = sbq.pop_front();
          check("press_slot", 32'(bv), 32'(4'b0001 << s));
        end
        meas_hold = 0;
        meas_gap  = 0;
      end
      if (done) begin
        check("hold_ticks", 32'(meas_hold), 32'(HOLD_EFF));
        check("gap_ticks", 32'(meas_gap), 32'(GAP_TICKS));
      end

      prev_b    = bv;
      prev_busy = busy;
      cap_v     = req_valid;
      cap_slot  = req_slot;
      pend_tick = timedClk & ~tc_last;
      tc_last   = timedClk;
    end
  end

  task automatic drive_random(input int cycles, input int pct);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      req_valid = ($urandom_range(0, 99) < pct);
      req_slot  = 2'($urandom_range(0, 3));
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = !busy && (level == '0);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_tick_rise(input string name);
    bit   ok;
    logic prev;
    ok   = 1'b0;
    prev = timedClk;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #3;
      ok   = timedClk && !prev;
      prev = timedClk;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin : stimulus
    int slots[3];
    bit seen;
    slots = '{2, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    check("reset_buttons", 32'({b4, b3, b2, b1}), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    drive_random(1500, 15);
    drive_random(400, 90);
    wait_idle("drain_before_reset_test");

    // Queue b3 then two more, and pull reset in the middle of the b3 press.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_slot  = 2'(slots[k]);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (b3) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("b3_pressed", 32'(seen), 32'd1);
    check("queued_behind_b3", 32'(level), 32'd2);
    wait_tick_rise("first_tick_of_b3");
    wait_tick_rise("second_tick_of_b3");
    check("b3_still_held", 32'(b3), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_b3_low", 32'(b3), 32'd0);
    check("async_level_cleared", 32'(level), 32'd0);
    check("async_busy_low", 32'(busy), 32'd0);
    check("async_no_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", 32'(req_ready), 32'd1);
    check("idle_after_release", 32'(busy), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("no_press_after_release", 32'({b4, b3, b2, b1}), 32'd0);
    check("no_done_after_release", 32'(done), 32'd0);

    drive_random(600, 40);
    wait_idle("final_drain");
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
